// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// Frame capture sequencer: takes the free-running AD9643 sample stream,
// waits for the configured trigger, and delivers exactly cfg_frame_len
// samples per enabled channel on two AXI-Stream masters, with tlast on the
// final beat. The ADC side has no back-pressure, so a sample that cannot be
// stored is dropped and counted rather than stalling the input.

module adc_capture_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  m_axis_aclk,
  input  logic                  reset,

  // register-bank controls, already in this clock domain
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [1:0]            cfg_trig_mode,
  input  logic [1:0]            cfg_ch_en,
  input  logic                  ext_trig,

  // deserialised ADC sample stream
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data_a,
  input  logic [DATA_WIDTH-1:0] adc_data_b,
  input  logic                  adc_or,

  // channel A stream
  output logic                  m_axis_tvalid_chA,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_chA,
  output logic                  m_axis_tlast_chA,
  input  logic                  m_axis_tready_chA,

  // channel B stream
  output logic                  m_axis_tvalid_chB,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_chB,
  output logic                  m_axis_tlast_chB,
  input  logic                  m_axis_tready_chB,

  // status
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic [1:0]            sts_state,
  output logic [15:0]           ovf_count,
  output logic [15:0]           drop_cnt_a,
  output logic [15:0]           drop_cnt_b
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_OVF_EDGE  = 2'd1;
  localparam logic [1:0] TRIG_EXT_LEVEL = 2'd2;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                 state_q;
  logic [LEN_WIDTH-1:0]   frame_len_q;   // latched at accepted start
  logic [1:0]             ch_en_q;       // latched at accepted start
  logic [LEN_WIDTH-1:0]   sample_cnt_q;  // index of the next sample in the frame
  logic                   or_hist_q;     // adc_or of the previous valid sample
  logic                   done_q;
  logic [15:0]            ovf_cnt_q;
  logic [15:0]            drop_a_q;
  logic [15:0]            drop_b_q;

  // one-entry output register per channel
  logic                   tvalid_a_q;
  logic [DATA_WIDTH-1:0]  tdata_a_q;
  logic                   tlast_a_q;
  logic                   tvalid_b_q;
  logic [DATA_WIDTH-1:0]  tdata_b_q;
  logic                   tlast_b_q;

  // ---------------------------------------------------------------------------
  // Decode signals
  // ---------------------------------------------------------------------------
  logic                   start_ok;      // start request that may leave IDLE
  logic                   trig_hit;      // current valid sample fires the trigger
  logic                   or_rise;       // overflow rising edge on this sample
  logic                   offer;         // sample belongs to the frame
  logic                   offer_last;    // that sample is the frame's last
  logic [LEN_WIDTH-1:0]   last_idx;

  logic                   drain_a, take_a, load_a, ovw_a, drop_a;
  logic                   drain_b, take_b, load_b, ovw_b, drop_b;
  logic                   flush_done;

  // Saturating 16-bit increment shared by all event counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Frame-level decode: trigger, sample qualification and last-sample detect.
  // NOTE: every signal written in an always_comb gets a default at the top, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    start_ok   = 1'b0;
    trig_hit   = 1'b0;
    or_rise    = 1'b0;
    offer      = 1'b0;
    offer_last = 1'b0;
    last_idx   = frame_len_q - LEN_WIDTH'(1);

    start_ok = cfg_start && (cfg_frame_len != '0) && (cfg_ch_en != 2'b00);
    or_rise  = adc_valid && adc_or && !or_hist_q;

    // Reserved mode 3 behaves as immediate.
    unique case (cfg_trig_mode)
      TRIG_OVF_EDGE:  trig_hit = or_rise;
      TRIG_EXT_LEVEL: trig_hit = adc_valid && ext_trig;
      default:        trig_hit = adc_valid;
    endcase

    unique case (state_q)
      ST_ARMED: begin
        offer      = trig_hit;
        offer_last = (frame_len_q == LEN_WIDTH'(1));
      end
      ST_CAPTURE: begin
        offer      = adc_valid;
        offer_last = (sample_cnt_q == last_idx);
      end
      default: begin
        offer      = 1'b0;
        offer_last = 1'b0;
      end
    endcase
  end

  // Per-channel output register decisions: load, last-sample overwrite, drop.
  always_comb begin
    drain_a = tvalid_a_q && m_axis_tready_chA;
    take_a  = offer && ch_en_q[0];
    load_a  = take_a && (!tvalid_a_q || drain_a);
    ovw_a   = take_a && !load_a && offer_last;
    drop_a  = take_a && !load_a;

    drain_b = tvalid_b_q && m_axis_tready_chB;
    take_b  = offer && ch_en_q[1];
    load_b  = take_b && (!tvalid_b_q || drain_b);
    ovw_b   = take_b && !load_b && offer_last;
    drop_b  = take_b && !load_b;

    // Both registers will be empty after this edge; disabled channels never
    // hold data, so their tvalid is already 0.
    flush_done = (state_q == ST_FLUSH)
              && (!tvalid_a_q || drain_a)
              && (!tvalid_b_q || drain_b);
  end

  // Sequencer, counters and output registers.
  // NOTE: clocked state is updated with non-blocking assignments only, so every
  // read in this block sees the value from before the edge.
  always_ff @(posedge m_axis_aclk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_len_q  <= '0;
      ch_en_q      <= 2'b00;
      sample_cnt_q <= '0;
      or_hist_q    <= 1'b0;
      done_q       <= 1'b0;
      ovf_cnt_q    <= '0;
      drop_a_q     <= '0;
      drop_b_q     <= '0;
      tvalid_a_q   <= 1'b0;
      tdata_a_q    <= '0;
      tlast_a_q    <= 1'b0;
      tvalid_b_q   <= 1'b0;
      tdata_b_q    <= '0;
      tlast_b_q    <= 1'b0;
    end else if (cfg_abort) begin
      // Abort discards any held beat without counting it; counters hold.
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      tvalid_a_q <= 1'b0;
      tlast_a_q  <= 1'b0;
      tvalid_b_q <= 1'b0;
      tlast_b_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            frame_len_q  <= cfg_frame_len;
            ch_en_q      <= cfg_ch_en;
            sample_cnt_q <= '0;
            or_hist_q    <= 1'b0;
            done_q       <= 1'b0;
            ovf_cnt_q    <= '0;
            drop_a_q     <= '0;
            drop_b_q     <= '0;
            state_q      <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (adc_valid) begin
            or_hist_q <= adc_or;
          end
          if (trig_hit) begin
            sample_cnt_q <= LEN_WIDTH'(1);
            state_q      <= offer_last ? ST_FLUSH : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (adc_valid) begin
            or_hist_q    <= adc_or;
            sample_cnt_q <= sample_cnt_q + LEN_WIDTH'(1);
            if (offer_last) begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_done) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Overflow edges only count for samples that belong to the frame,
      // which includes a mode-1 trigger sample.
      if (offer && or_rise) begin
        ovf_cnt_q <= sat_inc(ovf_cnt_q);
      end

      // Channel A register
      if (load_a) begin
        tvalid_a_q <= 1'b1;
        tdata_a_q  <= adc_data_a;
        tlast_a_q  <= offer_last;
      end else if (ovw_a) begin
        tdata_a_q  <= adc_data_a;
        tlast_a_q  <= 1'b1;
      end else if (drain_a) begin
        tvalid_a_q <= 1'b0;
        tlast_a_q  <= 1'b0;
      end
      if (drop_a) begin
        drop_a_q <= sat_inc(drop_a_q);
      end

      // Channel B register
      if (load_b) begin
        tvalid_b_q <= 1'b1;
        tdata_b_q  <= adc_data_b;
        tlast_b_q  <= offer_last;
      end else if (ovw_b) begin
        tdata_b_q  <= adc_data_b;
        tlast_b_q  <= 1'b1;
      end else if (drain_b) begin
        tvalid_b_q <= 1'b0;
        tlast_b_q  <= 1'b0;
      end
      if (drop_b) begin
        drop_b_q <= sat_inc(drop_b_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all driven straight from registers)
  // ---------------------------------------------------------------------------
  assign m_axis_tvalid_chA = tvalid_a_q;
  assign m_axis_tdata_chA  = tdata_a_q;
  assign m_axis_tlast_chA  = tlast_a_q;
  assign m_axis_tvalid_chB = tvalid_b_q;
  assign m_axis_tdata_chB  = tdata_b_q;
  assign m_axis_tlast_chB  = tlast_b_q;

  assign sts_busy   = (state_q != ST_IDLE);
  assign sts_done   = done_q;
  assign sts_state  = state_q;
  assign ovf_count  = ovf_cnt_q;
  assign drop_cnt_a = drop_a_q;
  assign drop_cnt_b = drop_b_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed testbench for adc_capture_ctrl. Inputs change 1 ns after each
// rising edge; outputs are inspected at that same point, i.e. they show the
// result of the edge just taken. Handshaken beats are logged per channel.

module tb_adc_capture_ctrl;

  localparam int DW = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start, cfg_abort;
  logic [LW-1:0] cfg_frame_len;
  logic [1:0]    cfg_trig_mode, cfg_ch_en;
  logic          ext_trig, adc_valid, adc_or;
  logic [DW-1:0] adc_data_a, adc_data_b;
  logic          tvalid_a, tlast_a, tready_a;
  logic          tvalid_b, tlast_b, tready_b;
  logic [DW-1:0] tdata_a, tdata_b;
  logic          sts_busy, sts_done;
  logic [1:0]    sts_state;
  logic [15:0]   ovf_count, drop_cnt_a, drop_cnt_b;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] qa_data[$];
  logic          qa_last[$];
  logic [DW-1:0] qb_data[$];
  logic          qb_last[$];

  always #5 clk = ~clk;

  adc_capture_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .m_axis_aclk       (clk),
    .reset             (reset),
    .cfg_start         (cfg_start),
    .cfg_abort         (cfg_abort),
    .cfg_frame_len     (cfg_frame_len),
    .cfg_trig_mode     (cfg_trig_mode),
    .cfg_ch_en         (cfg_ch_en),
    .ext_trig          (ext_trig),
    .adc_valid         (adc_valid),
    .adc_data_a        (adc_data_a),
    .adc_data_b        (adc_data_b),
    .adc_or            (adc_or),
    .m_axis_tvalid_chA (tvalid_a),
    .m_axis_tdata_chA  (tdata_a),
    .m_axis_tlast_chA  (tlast_a),
    .m_axis_tready_chA (tready_a),
    .m_axis_tvalid_chB (tvalid_b),
    .m_axis_tdata_chB  (tdata_b),
    .m_axis_tlast_chB  (tlast_b),
    .m_axis_tready_chB (tready_b),
    .sts_busy          (sts_busy),
    .sts_done          (sts_done),
    .sts_state         (sts_state),
    .ovf_count         (ovf_count),
    .drop_cnt_a        (drop_cnt_a),
    .drop_cnt_b        (drop_cnt_b)
  );

  // Log any beat that handshakes at the coming edge, then advance one cycle.
  task automatic cycle();
    if (tvalid_a && tready_a) begin
      qa_data.push_back(tdata_a);
      qa_last.push_back(tlast_a);
    end
    if (tvalid_b && tready_b) begin
      qb_data.push_back(tdata_b);
      qb_last.push_back(tlast_b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    qa_data.delete(); qa_last.delete();
    qb_data.delete(); qb_last.delete();
  endtask

  task automatic start_frame(input int len, input int mode, input int en);
    cfg_frame_len = LW'(len);
    cfg_trig_mode = 2'(mode);
    cfg_ch_en     = 2'(en);
    cfg_start     = 1'b1;
    cycle();
    cfg_start     = 1'b0;
  endtask

  // Bounded wait for sts_done; a timeout shows up in the caller's done check.
  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles && !sts_done; i++) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    tests_run++;
    if ({tvalid_a, tvalid_b, tlast_a, tlast_b, sts_busy, sts_done} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 000000",
               {tvalid_a, tvalid_b, tlast_a, tlast_b, sts_busy, sts_done});
    end
    tests_run++;
    if ({tdata_a, tdata_b, ovf_count, drop_cnt_a, drop_cnt_b, sts_state} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: tdata_a=%h tdata_b=%h ovf=%0d drop_a=%0d drop_b=%0d state=%0d required all 0",
               tdata_a, tdata_b, ovf_count, drop_cnt_a, drop_cnt_b, sts_state);
    end
  endtask

  task automatic test_immediate();
    int errs = 0;
    clear_beats();
    start_frame(8, 0, 3);
    tests_run++;
    if (sts_state !== 2'd1) begin
      tests_failed++;
      $display("FAIL imm_armed: state %0d required 1", sts_state);
    end
    for (int i = 0; i < 8; i++) begin
      adc_valid = 1'b1; adc_data_a = DW'(100 + i); adc_data_b = DW'(200 + i);
      cycle();
    end
    adc_valid = 1'b0;
    wait_done(20);
    tests_run++;
    if (qa_data.size() != 8 || qb_data.size() != 8) begin
      tests_failed++;
      $display("FAIL imm_beats: got a=%0d b=%0d required 8 8", qa_data.size(), qb_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (qa_data[i] !== DW'(100 + i) || qa_last[i] !== (i == 7)) errs++;
        if (qb_data[i] !== DW'(200 + i) || qb_last[i] !== (i == 7)) errs++;
      end
      tests_run++;
      if (errs != 0) begin
        tests_failed++;
        $display("FAIL imm_ramp: %0d wrong beats, required 0", errs);
      end
    end
    tests_run++;
    if (sts_done !== 1'b1 || sts_state !== 2'd0 || drop_cnt_a !== 16'd0 || drop_cnt_b !== 16'd0) begin
      tests_failed++;
      $display("FAIL imm_status: done=%b state=%0d drop_a=%0d drop_b=%0d required 1 0 0 0",
               sts_done, sts_state, drop_cnt_a, drop_cnt_b);
    end
  endtask

  task automatic test_ovf_trigger();
    clear_beats();
    start_frame(16, 1, 1);
    tests_run++;
    if (sts_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_done_clear: done %b required 0", sts_done);
    end
    for (int i = 0; i < 20; i++) begin
      adc_valid = 1'b1; adc_data_a = DW'(300 + i); adc_data_b = DW'(400 + i);
      adc_or = (i == 2 || i == 5);
      cycle();
    end
    adc_valid = 1'b0; adc_or = 1'b0;
    wait_done(20);
    tests_run++;
    if (qa_data.size() != 16 || qa_data[0] !== 16'd302 || qa_data[15] !== 16'd317 || qa_last[15] !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_frame: beats=%0d first=%0d last=%0d required 16 302 317",
               qa_data.size(), qa_data[0], qa_data[qa_data.size()-1]);
    end
    tests_run++;
    if (ovf_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL ovf_count: got %0d required 2", ovf_count);
    end
    tests_run++;
    if (qb_data.size() != 0 || sts_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_chB_idle: b beats=%0d done=%b required 0 1", qb_data.size(), sts_done);
    end
  endtask

  task automatic test_back_pressure();
    clear_beats();
    start_frame(32, 0, 3);
    for (int c = 0; c < 60 && !sts_done; c++) begin
      tready_a = (c % 27) < 25;
      tready_b = (c % 28) < 25;
      adc_valid = 1'b1; adc_data_a = DW'(1000 + c); adc_data_b = DW'(2000 + c);
      cycle();
    end
    adc_valid = 1'b0; tready_a = 1'b1; tready_b = 1'b1;
    tests_run++;
    if (drop_cnt_a !== 16'd2 || drop_cnt_b !== 16'd3) begin
      tests_failed++;
      $display("FAIL bp_drops: got a=%0d b=%0d required 2 3", drop_cnt_a, drop_cnt_b);
    end
    tests_run++;
    if (qa_data.size() != 30 || qb_data.size() != 29) begin
      tests_failed++;
      $display("FAIL bp_beats: got a=%0d b=%0d required 30 29", qa_data.size(), qb_data.size());
    end
    tests_run++;
    if (qa_data[qa_data.size()-1] !== 16'd1031 || qa_last[qa_last.size()-1] !== 1'b1 ||
        qb_data[qb_data.size()-1] !== 16'd2031 || qb_last[qb_last.size()-1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_last: got a=%0d/%b b=%0d/%b required 1031/1 2031/1",
               qa_data[qa_data.size()-1], qa_last[qa_last.size()-1],
               qb_data[qb_data.size()-1], qb_last[qb_last.size()-1]);
    end
    tests_run++;
    if (sts_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_done: got %b required 1", sts_done);
    end
  endtask

  task automatic test_last_overwrite();
    clear_beats();
    start_frame(4, 0, 3);
    for (int c = 0; c < 8; c++) begin
      tready_b  = !(c >= 3);
      adc_valid = (c < 4); adc_data_a = DW'(500 + c); adc_data_b = DW'(600 + c);
      if (c == 3) begin
        tests_run++;
        if (tvalid_b !== 1'b1 || tdata_b !== 16'd602) begin
          tests_failed++;
          $display("FAIL ovw_hold: tvalid=%b tdata=%0d required 1 602", tvalid_b, tdata_b);
        end
      end
      if (c == 6) begin
        tests_run++;
        if (sts_state !== 2'd3 || tvalid_b !== 1'b1 || tdata_b !== 16'd603 || tlast_b !== 1'b1) begin
          tests_failed++;
          $display("FAIL ovw_flush: state=%0d tvalid=%b tdata=%0d tlast=%b required 3 1 603 1",
                   sts_state, tvalid_b, tdata_b, tlast_b);
        end
      end
      cycle();
    end
    adc_valid = 1'b0; tready_b = 1'b1;
    wait_done(10);
    tests_run++;
    if (drop_cnt_b !== 16'd1 || drop_cnt_a !== 16'd0) begin
      tests_failed++;
      $display("FAIL ovw_drops: got a=%0d b=%0d required 0 1", drop_cnt_a, drop_cnt_b);
    end
    tests_run++;
    if (qa_data.size() != 4 || qb_data.size() != 3 || qb_data[2] !== 16'd603 || qb_last[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovw_beats: a=%0d b=%0d b_last=%0d required 4 3 603",
               qa_data.size(), qb_data.size(), qb_data[2]);
    end
    tests_run++;
    if (sts_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovw_done: got %b required 1", sts_done);
    end
  endtask

  task automatic test_abort();
    clear_beats();
    start_frame(100, 0, 3);
    for (int c = 0; c <= 10; c++) begin
      adc_valid = 1'b1; adc_data_a = DW'(700 + c); adc_data_b = DW'(800 + c);
      cfg_abort = (c == 10);
      cycle();
    end
    cfg_abort = 1'b0; adc_valid = 1'b0;
    tests_run++;
    if (tvalid_a !== 1'b0 || tvalid_b !== 1'b0 || sts_state !== 2'd0 || sts_done !== 1'b0 || sts_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: tvalid=%b%b state=%0d done=%b busy=%b required 00 0 0 0",
               tvalid_a, tvalid_b, sts_state, sts_done, sts_busy);
    end
    clear_beats();
    start_frame(4, 0, 3);
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1; adc_data_a = DW'(900 + i); adc_data_b = DW'(950 + i);
      cycle();
    end
    adc_valid = 1'b0;
    wait_done(10);
    tests_run++;
    if (sts_done !== 1'b1 || qa_data.size() != 4 || qb_data.size() != 4 || qa_data[3] !== 16'd903) begin
      tests_failed++;
      $display("FAIL abort_restart: done=%b a=%0d b=%0d a_last=%0d required 1 4 4 903",
               sts_done, qa_data.size(), qb_data.size(), qa_data[3]);
    end
  endtask

  task automatic test_illegal_start();
    start_frame(0, 0, 3);
    tests_run++;
    if (sts_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL ill_len0: state %0d required 0", sts_state);
    end
    start_frame(5, 0, 0);
    tests_run++;
    if (sts_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL ill_en0: state %0d required 0", sts_state);
    end
    clear_beats();
    start_frame(6, 0, 1);
    for (int c = 0; c < 6; c++) begin
      adc_valid = 1'b1; adc_data_a = DW'(40 + c); adc_data_b = DW'(0);
      if (c == 2) begin
        cfg_frame_len = 16'd3; cfg_start = 1'b1;
      end
      cycle();
      cfg_start = 1'b0;
    end
    adc_valid = 1'b0;
    wait_done(10);
    tests_run++;
    if (qa_data.size() != 6 || qa_data[5] !== 16'd45 || qa_last[5] !== 1'b1) begin
      tests_failed++;
      $display("FAIL ill_busy_start: beats=%0d last=%0d required 6 45",
               qa_data.size(), qa_data[qa_data.size()-1]);
    end
    start_frame(4, 0, 1);
    cfg_start = 1'b1; cfg_abort = 1'b1;
    cycle();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    tests_run++;
    if (sts_state !== 2'd0 || sts_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL ill_start_abort: state=%0d done=%b required 0 0", sts_state, sts_done);
    end
  endtask

  task automatic test_reset_mid_capture();
    start_frame(32, 0, 1);
    tready_a = 1'b0;
    for (int c = 0; c < 6; c++) begin
      adc_valid = 1'b1; adc_data_a = DW'(c);
      cycle();
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0; adc_valid = 1'b0; tready_a = 1'b1;
    tests_run++;
    if (drop_cnt_a !== 16'd0 || sts_state !== 2'd0 || tvalid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid: drop_a=%0d state=%0d tvalid=%b required 0 0 0",
               drop_cnt_a, sts_state, tvalid_a);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_frame_len = '0; cfg_trig_mode = 2'd0; cfg_ch_en = 2'd0;
    ext_trig = 1'b0; adc_valid = 1'b0; adc_or = 1'b0;
    adc_data_a = '0; adc_data_b = '0;
    tready_a = 1'b1; tready_b = 1'b1;
    #1;
    test_reset();
    test_immediate();
    test_ovf_trigger();
    test_back_pressure();
    test_last_overwrite();
    test_abort();
    test_illegal_start();
    test_reset_mid_capture();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
